// File: rtl/tcdm_addr_guard.sv
// ---------------------------------------------------------------------------
// tcdm_addr_guard
//
// Sits between one TCDM master and two slaves. The memory side owns the
// mapped window (MEM_BASE/MEM_MASK); every other address goes to the error
// side. The module steers each request by address, returns the one-cycle
// delayed response from the side that granted it, flags any error-side
// response as a bus error, and records the first unmapped access. A
// saturating counter tracks how many unmapped accesses occurred.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   m_*                      master-side request / grant / response
//   s_*                      memory-side request / grant / response
//   e_*                      error-side request / grant / response
//   err_clr_i                clears the capture and the counter
//   err_valid_o              sticky flag: an unmapped access was granted
//   err_addr_o, err_wen_o    address / wen of the first unmapped access
//   err_cnt_o                saturating count of unmapped accesses
// ---------------------------------------------------------------------------
module tcdm_addr_guard #(
    parameter logic [31:0] MEM_BASE = 32'h1C00_0000,
    parameter logic [31:0] MEM_MASK = 32'hFFF0_0000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // master side
    input  logic             m_req_i,
    input  logic [31:0]      m_add_i,
    input  logic             m_wen_i,
    input  logic [35:0]      m_wdata_i,
    input  logic [3:0]       m_be_i,
    output logic             m_gnt_o,
    output logic [35:0]      m_r_rdata_o,
    output logic             m_r_valid_o,
    output logic             m_r_opc_o,
    // memory side
    output logic             s_req_o,
    output logic [31:0]      s_add_o,
    output logic             s_wen_o,
    output logic [35:0]      s_wdata_o,
    output logic [3:0]       s_be_o,
    input  logic             s_gnt_i,
    input  logic             s_r_valid_i,
    input  logic             s_r_opc_i,
    input  logic [35:0]      s_r_rdata_i,
    // error side
    output logic             e_req_o,
    output logic [31:0]      e_add_o,
    output logic             e_wen_o,
    output logic [35:0]      e_wdata_o,
    output logic [3:0]       e_be_o,
    input  logic             e_gnt_i,
    input  logic             e_r_valid_i,
    input  logic             e_r_opc_i,
    input  logic [35:0]      e_r_rdata_i,
    // error capture
    input  logic             err_clr_i,
    output logic             err_valid_o,
    output logic [31:0]      err_addr_o,
    output logic             err_wen_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        CAPTURED = 1'b1
    } cap_state_e;

    logic             hit;
    logic             hs;
    logic             err_hs;
    logic             sel_q;      // 1: the outstanding response belongs to the error side
    cap_state_e       state_q, state_d;
    logic [31:0]      err_addr_q, err_addr_d;
    logic             err_wen_q, err_wen_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // ---------------- request path (purely combinational) ----------------
    assign hit     = ((m_add_i & MEM_MASK) == (MEM_BASE & MEM_MASK));

    assign s_req_o   = m_req_i & hit;
    assign s_add_o   = m_add_i;
    assign s_wen_o   = m_wen_i;
    assign s_wdata_o = m_wdata_i;
    assign s_be_o    = m_be_i;

    assign e_req_o   = m_req_i & ~hit;
    assign e_add_o   = m_add_i;
    assign e_wen_o   = m_wen_i;
    assign e_wdata_o = m_wdata_i;
    assign e_be_o    = m_be_i;

    assign m_gnt_o = hit ? s_gnt_i : e_gnt_i;
    assign hs      = m_req_i & m_gnt_o;
    assign err_hs  = hs & ~hit;

    // ---------------- response path ----------------
    assign m_r_valid_o = sel_q ? e_r_valid_i : s_r_valid_i;
    assign m_r_rdata_o = sel_q ? e_r_rdata_i : s_r_rdata_i;
    // Anything answered by the error side is a bus error, whatever it reports.
    assign m_r_opc_o   = sel_q ? (e_r_opc_i | 1'b1) : s_r_opc_i;

    // ---------------- capture next-state logic ----------------
    // NOTE: every always_comb target gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        err_addr_d = err_addr_q;
        err_wen_d  = err_wen_q;
        err_cnt_d  = err_cnt_q;

        if (err_clr_i) begin
            state_d   = IDLE;
            err_cnt_d = '0;
        end

        // A clear in the same cycle as an error re-arms the capture, so the
        // new access is the one recorded and the count restarts at one.
        if (err_hs) begin
            if ((state_q == IDLE) || err_clr_i) begin
                state_d    = CAPTURED;
                err_addr_d = m_add_i;
                err_wen_d  = m_wen_i;
            end
            if (err_clr_i) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q      <= 1'b0;
            state_q    <= IDLE;
            err_addr_q <= '0;
            err_wen_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (hs) begin
                sel_q <= ~hit;
            end
            state_q    <= state_d;
            err_addr_q <= err_addr_d;
            err_wen_q  <= err_wen_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_valid_o = (state_q == CAPTURED);
    assign err_addr_o  = err_addr_q;
    assign err_wen_o   = err_wen_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_tcdm_addr_guard.sv
// ---------------------------------------------------------------------------
// tb_tcdm_addr_guard
//
// Drives two guards in parallel (default CNT_W=8 and CNT_W=2) from the same
// master/slave stimulus. Inputs change on the falling edge; outputs are
// sampled 1 ns later. A behavioural model tracks which side answered the
// last granted access, the first-error record, and the unmapped-access
// counts as plain integers, and is advanced after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tcdm_addr_guard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m_req_i;
    logic [31:0] m_add_i;
    logic        m_wen_i;
    logic [35:0] m_wdata_i;
    logic [3:0]  m_be_i;
    logic        s_gnt_i, s_r_valid_i, s_r_opc_i;
    logic [35:0] s_r_rdata_i;
    logic        e_gnt_i, e_r_valid_i, e_r_opc_i;
    logic [35:0] e_r_rdata_i;
    logic        err_clr_i;

    logic        m_gnt_o, m_r_valid_o, m_r_opc_o;
    logic [35:0] m_r_rdata_o;
    logic        s_req_o, s_wen_o, e_req_o, e_wen_o;
    logic [31:0] s_add_o, e_add_o;
    logic [35:0] s_wdata_o, e_wdata_o;
    logic [3:0]  s_be_o, e_be_o;
    logic        err_valid_o, err_wen_o;
    logic [31:0] err_addr_o;
    logic [7:0]  err_cnt_o;

    // outputs of the narrow-counter instance
    logic        m2_gnt, m2_r_valid, m2_r_opc;
    logic [35:0] m2_r_rdata;
    logic        s2_req, s2_wen, e2_req, e2_wen;
    logic [31:0] s2_add, e2_add;
    logic [35:0] s2_wdata, e2_wdata;
    logic [3:0]  s2_be, e2_be;
    logic        err2_valid, err2_wen;
    logic [31:0] err2_addr;
    logic [1:0]  err2_cnt;

    always #5 clk_i = ~clk_i;

    tcdm_addr_guard dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
        .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_gnt_o(m_gnt_o),
        .m_r_rdata_o(m_r_rdata_o), .m_r_valid_o(m_r_valid_o), .m_r_opc_o(m_r_opc_o),
        .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o),
        .s_wdata_o(s_wdata_o), .s_be_o(s_be_o), .s_gnt_i(s_gnt_i),
        .s_r_valid_i(s_r_valid_i), .s_r_opc_i(s_r_opc_i), .s_r_rdata_i(s_r_rdata_i),
        .e_req_o(e_req_o), .e_add_o(e_add_o), .e_wen_o(e_wen_o),
        .e_wdata_o(e_wdata_o), .e_be_o(e_be_o), .e_gnt_i(e_gnt_i),
        .e_r_valid_i(e_r_valid_i), .e_r_opc_i(e_r_opc_i), .e_r_rdata_i(e_r_rdata_i),
        .err_clr_i(err_clr_i), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
        .err_wen_o(err_wen_o), .err_cnt_o(err_cnt_o)
    );

    tcdm_addr_guard #(.CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
        .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_gnt_o(m2_gnt),
        .m_r_rdata_o(m2_r_rdata), .m_r_valid_o(m2_r_valid), .m_r_opc_o(m2_r_opc),
        .s_req_o(s2_req), .s_add_o(s2_add), .s_wen_o(s2_wen),
        .s_wdata_o(s2_wdata), .s_be_o(s2_be), .s_gnt_i(s_gnt_i),
        .s_r_valid_i(s_r_valid_i), .s_r_opc_i(s_r_opc_i), .s_r_rdata_i(s_r_rdata_i),
        .e_req_o(e2_req), .e_add_o(e2_add), .e_wen_o(e2_wen),
        .e_wdata_o(e2_wdata), .e_be_o(e2_be), .e_gnt_i(e_gnt_i),
        .e_r_valid_i(e_r_valid_i), .e_r_opc_i(e_r_opc_i), .e_r_rdata_i(e_r_rdata_i),
        .err_clr_i(err_clr_i), .err_valid_o(err2_valid), .err_addr_o(err2_addr),
        .err_wen_o(err2_wen), .err_cnt_o(err2_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    // The window is the 1 MiB region whose top 12 address bits are 0x1C0.
    bit          mdl_last_err;   // last granted access went to an unmapped address
    bit          mdl_captured;
    logic [31:0] mdl_addr;
    logic        mdl_wen;
    int          mdl_cnt8, mdl_cnt2;

    function automatic bit in_window(input logic [31:0] a);
        return (a / 32'h0010_0000) == 32'h1C0;
    endfunction

    task automatic model_reset();
        mdl_last_err = 1'b0;
        mdl_captured = 1'b0;
        mdl_addr     = 32'h0;
        mdl_wen      = 1'b0;
        mdl_cnt8     = 0;
        mdl_cnt2     = 0;
    endtask

    // One clock cycle: drive inputs, check all outputs, advance the model.
    task automatic cycle(input logic req, input logic [31:0] addr, input logic wen,
                         input logic sg, input logic eg, input logic clr, input logic rst);
        bit mapped, granted;
        @(negedge clk_i);
        m_req_i     = req;
        m_add_i     = addr;
        m_wen_i     = wen;
        m_wdata_i   = {$urandom_range(15, 0), $urandom()};
        m_be_i      = 4'($urandom_range(15, 0));
        s_gnt_i     = sg;
        e_gnt_i     = eg;
        err_clr_i   = clr;
        rst_i       = rst;
        s_r_valid_i = 1'($urandom_range(1, 0));
        s_r_opc_i   = 1'($urandom_range(1, 0));
        s_r_rdata_i = {$urandom_range(15, 0), $urandom()};
        e_r_valid_i = 1'($urandom_range(1, 0));
        e_r_opc_i   = 1'($urandom_range(1, 0));
        e_r_rdata_i = {$urandom_range(15, 0), $urandom()};
        #1;
        mapped  = in_window(addr);
        granted = mapped ? sg : eg;

        check("s_req",   36'(s_req_o), 36'(req && mapped));
        check("e_req",   36'(e_req_o), 36'(req && !mapped));
        check("m_gnt",   36'(m_gnt_o), 36'(granted));
        check("s_add",   36'(s_add_o), 36'(addr));
        check("e_add",   36'(e_add_o), 36'(addr));
        check("wen_bc",  36'({s_wen_o, e_wen_o}), 36'({wen, wen}));
        check("wdata",   e_wdata_o ^ s_wdata_o ^ m_wdata_i, m_wdata_i);
        check("be_bc",   36'({s_be_o, e_be_o}), 36'({m_be_i, m_be_i}));

        if (mdl_last_err) begin
            check("r_valid", 36'(m_r_valid_o), 36'(e_r_valid_i));
            check("r_rdata", m_r_rdata_o, e_r_rdata_i);
            check("r_opc",   36'(m_r_opc_o), 36'(1));
        end else begin
            check("r_valid", 36'(m_r_valid_o), 36'(s_r_valid_i));
            check("r_rdata", m_r_rdata_o, s_r_rdata_i);
            check("r_opc",   36'(m_r_opc_o), 36'(s_r_opc_i));
        end

        check("err_valid", 36'(err_valid_o), 36'(mdl_captured));
        check("err_addr",  36'(err_addr_o),  36'(mdl_addr));
        check("err_wen",   36'(err_wen_o),   36'(mdl_wen));
        check("err_cnt8",  36'(err_cnt_o),   36'(mdl_cnt8));
        check("err_cnt2",  36'(err2_cnt),    36'(mdl_cnt2));
        check("err2_valid", 36'(err2_valid), 36'(mdl_captured));

        @(posedge clk_i);
        if (rst) begin
            model_reset();
        end else begin
            if (req && granted) mdl_last_err = !mapped;
            if (clr) begin
                mdl_captured = 1'b0;
                mdl_cnt8     = 0;
                mdl_cnt2     = 0;
            end
            if (req && granted && !mapped) begin
                if (!mdl_captured) begin
                    mdl_captured = 1'b1;
                    mdl_addr     = addr;
                    mdl_wen      = wen;
                end
                if (mdl_cnt8 < 255) mdl_cnt8++;
                if (mdl_cnt2 < 3)   mdl_cnt2++;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(1, 0) == 0)
            return 32'h1C00_0000 | 32'($urandom_range(32'h000F_FFFF, 0));
        return $urandom();
    endfunction

    initial begin
        m_req_i = 0; m_add_i = 0; m_wen_i = 1; m_wdata_i = 0; m_be_i = 0;
        s_gnt_i = 0; e_gnt_i = 0; s_r_valid_i = 0; s_r_opc_i = 0; s_r_rdata_i = 0;
        e_r_valid_i = 0; e_r_opc_i = 0; e_r_rdata_i = 0; err_clr_i = 0; rst_i = 1;
        repeat (2) @(posedge clk_i);
        model_reset();

        // reset held one more cycle: everything still zero
        cycle(0, 32'h0, 1, 0, 0, 0, 1);

        // mapped read, then idle to observe the memory-side response
        cycle(1, 32'h1C00_0010, 1, 1, 0, 0, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);

        // unmapped write
        cycle(1, 32'h2000_0000, 0, 0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);
        check("req016_addr", 36'(err_addr_o), 36'(32'h2000_0000));

        // back-to-back mapped, unmapped, mapped
        cycle(1, 32'h1C00_0100, 1, 1, 1, 0, 0);
        cycle(1, 32'h5000_0000, 1, 1, 1, 0, 0);
        cycle(1, 32'h1C0F_FFFC, 0, 1, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);

        // clear, then two errors: first address sticks
        cycle(0, 32'h0, 1, 0, 0, 1, 0);
        cycle(1, 32'h3000_0000, 1, 0, 1, 0, 0);
        cycle(1, 32'h4000_0000, 0, 0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);
        check("req018_addr", 36'(err_addr_o), 36'(32'h3000_0000));
        check("req018_cnt",  36'(err_cnt_o), 36'(2));
        cycle(0, 32'h0, 1, 0, 0, 1, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);

        // five errors saturate the 2-bit counter; then clear + error
        for (int i = 0; i < 5; i++) cycle(1, 32'h6000_0000 + 32'(i * 4), 1, 0, 1, 0, 0);
        cycle(1, 32'h7000_0040, 0, 0, 1, 1, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);
        check("req019_cnt2", 36'(err2_cnt), 36'(1));
        check("req019_addr", 36'(err_addr_o), 36'(32'h7000_0040));

        // ungranted unmapped request leaves routing alone
        cycle(1, 32'h8000_0000, 1, 1, 0, 0, 0);

        // reset right after an unmapped handshake
        cycle(1, 32'h9000_0000, 1, 0, 1, 0, 0);
        cycle(0, 32'h0, 1, 0, 0, 0, 1);
        cycle(0, 32'h0, 1, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(9, 0) < 7), rand_addr(), 1'($urandom_range(1, 0)),
                  1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
                  1'($urandom_range(29, 0) == 0), 1'($urandom_range(79, 0) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
